// File: rtl/bcd_to_bin.sv
// ============================================================================
// bcd_to_bin : two-digit BCD to 7-bit binary, reverse double-dabble, 7 cycles
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] tens_i,
   input  logic [3:0] ones_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [6:0] bin_o,
   output logic       err_o,
   output logic       valid_o,
   input  logic       ready_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  bcd_q;
   logic [6:0]  bin_q;
   logic [2:0]  cnt_q;
   logic [6:0]  res_q;
   logic        err_q;
   logic        valid_q;

   logic [14:0] shifted_d;
   logic [7:0]  bcd_d;
   logic [6:0]  bin_d;

   // One iteration: shift the whole word right, then pull 3 out of any nibble >= 8.
   always_comb begin
      shifted_d = {bcd_q, bin_q} >> 1;
      bcd_d     = shifted_d[14:7];
      bin_d     = shifted_d[6:0];
      if (bcd_d[7:4] >= 4'd8) bcd_d[7:4] = bcd_d[7:4] - 4'd3;
      if (bcd_d[3:0] >= 4'd8) bcd_d[3:0] = bcd_d[3:0] - 4'd3;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         bcd_q   <= 8'd0;
         bin_q   <= 7'd0;
         cnt_q   <= 3'd0;
         res_q   <= 7'd0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  bcd_q <= {tens_i, ones_i};
                  bin_q <= 7'd0;
                  cnt_q <= 3'd0;
                  if ((tens_i > 4'd9) || (ones_i > 4'd9)) begin
                     res_q   <= 7'd0;
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= CONVERT;
                  end
               end
            end
            CONVERT: begin
               bcd_q <= bcd_d;
               bin_q <= bin_d;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd6) begin
                  assert (bcd_d == 8'd0);
                  res_q   <= bin_d;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o = (state_q == IDLE);
   assign bin_o   = res_q;
   assign err_o   = err_q;
   assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
// tb_bcd_to_bin : vector table + scoreboard bench for bcd_to_bin
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_bin;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] tens_i = 4'd0;
   logic [3:0] ones_i = 4'd0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [6:0] bin_o;
   logic       err_o;
   logic       valid_o;
   logic       ready_i = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] sb[$];
   int         out_cyc[$];

   typedef struct {
      logic [3:0] t;
      logic [3:0] o;
      logic [6:0] b;
      logic       e;
   } vec_t;

   vec_t tbl[8];

   bcd_to_bin dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tens_i (tens_i),
      .ones_i (ones_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .bin_o  (bin_o),
      .err_o  (err_o),
      .valid_o(valid_o),
      .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Output monitor: an output handshake happens on the next edge.
   always @(negedge clk_i) begin
      if (!rst_i && valid_o && ready_i) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: bin_o=%0d err_o=%0b with nothing expected", bin_o, err_o);
         end else begin
            logic [7:0] exp;
            exp = sb.pop_front();
            if ({bin_o, err_o} !== exp) begin
               errors++;
               $display("FAIL result: got bin_o=%0d err_o=%0b, expected bin_o=%0d err_o=%0b",
                        bin_o, err_o, exp[7:1], exp[0]);
            end
            out_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [3:0] t, input logic [3:0] o,
                       input logic [6:0] eb, input logic ee);
      int n = 0;
      tens_i  = t;
      ones_i  = o;
      valid_i = 1'b1;
      @(negedge clk_i);
      while (!ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         check("accept_timeout", 0, 1);
      end else begin
         sb.push_back({eb, ee});
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   // Negedges with valid_o low after an acceptance edge.
   task automatic latency(output int n);
      n = 0;
      @(negedge clk_i);
      while (!valid_o && n < 50) begin
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_timeout", sb.size(), 0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int lat;
      int bad;
      tbl[0] = '{4'd9, 4'd9, 7'd99, 1'b0};
      tbl[1] = '{4'd0, 4'd0, 7'd0,  1'b0};
      tbl[2] = '{4'd4, 4'd2, 7'd42, 1'b0};
      tbl[3] = '{4'd1, 4'hA, 7'd0,  1'b1};
      tbl[4] = '{4'hF, 4'd0, 7'd0,  1'b1};
      tbl[5] = '{4'd9, 4'hF, 7'd0,  1'b1};
      tbl[6] = '{4'd7, 4'd0, 7'd70, 1'b0};
      tbl[7] = '{4'd1, 4'd9, 7'd19, 1'b0};

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_ready_o", ready_o, 1);
      check("reset_valid_o", valid_o, 0);
      check("reset_bin_o",   bin_o,   0);
      check("reset_err_o",   err_o,   0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Latency of a valid conversion, then ready_o returns
      send(4'd9, 4'd9, 7'd99, 1'b0);
      latency(lat);
      check("latency_valid", lat, 7);
      check("bin_99", bin_o, 99);
      @(negedge clk_i);
      check("ready_after_done", ready_o, 1);
      check("valid_after_done", valid_o, 0);

      // Latency of an error response
      @(posedge clk_i);
      #1;
      send(4'd1, 4'hA, 7'd0, 1'b1);
      latency(lat);
      check("latency_err", lat, 0);
      check("err_flag", err_o, 1);
      drain();

      for (int i = 0; i < 8; i++) send(tbl[i].t, tbl[i].o, tbl[i].b, tbl[i].e);
      drain();

      for (int t = 0; t < 10; t++)
         for (int o = 0; o < 10; o++)
            send(4'(t), 4'(o), 7'(10 * t + o), 1'b0);
      drain();

      // Back-pressure: hold 57, offer 12 which must wait
      ready_i = 1'b0;
      send(4'd5, 4'd7, 7'd57, 1'b0);
      latency(lat);
      tens_i  = 4'd1;
      ones_i  = 4'd2;
      valid_i = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (!valid_o || bin_o !== 7'd57 || err_o || ready_o) bad++;
         @(negedge clk_i);
      end
      check("backpressure_stable", bad, 0);
      @(posedge clk_i);
      #1;
      ready_i = 1'b1;
      send(4'd1, 4'd2, 7'd12, 1'b0);
      drain();

      // Reset in the third CONVERT cycle discards the result
      send(4'd8, 4'd8, 7'd88, 1'b0);
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      sb.delete();
      @(negedge clk_i);
      check("midreset_ready_o", ready_o, 1);
      check("midreset_valid_o", valid_o, 0);
      check("midreset_bin_o",   bin_o,   0);
      bad = 0;
      repeat (12) begin
         @(negedge clk_i);
         if (valid_o) bad++;
      end
      check("midreset_no_stale", bad, 0);
      @(posedge clk_i);
      #1;
      send(4'd3, 4'd1, 7'd31, 1'b0);
      drain();

      // Back-to-back: 25 then 63, results 9 cycles apart
      out_cyc.delete();
      send(4'd2, 4'd5, 7'd25, 1'b0);
      send(4'd6, 4'd3, 7'd63, 1'b0);
      drain();
      check("b2b_count", out_cyc.size(), 2);
      if (out_cyc.size() == 2) check("b2b_spacing", out_cyc[1] - out_cyc[0], 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
